// File: rtl/flash_save_sched.sv
// Save sequencer in front of the flash controller: splits one "save N words at A"
// request into block erases and buffer-sized program bursts, gated on source FIFO fill.
module flash_save_sched #(
  parameter int unsigned BUF_LOG2 = 9,
  parameter int unsigned BLK_LOG2 = 16,
  parameter int unsigned ADDR_W   = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                save_en,
  input  logic [ADDR_W-1:0]   save_addr,
  input  logic [ADDR_W-1:0]   save_length,
  input  logic                save_abort,
  input  logic [BUF_LOG2+1:0] fifo_count,
  output logic                busy,
  output logic                save_done,
  output logic                save_aborted,
  output logic                erase_en,
  output logic [ADDR_W-1:0]   erase_addr,
  input  logic                erase_done,
  output logic                prog_en,
  output logic [ADDR_W-1:0]   prog_addr,
  output logic [BUF_LOG2:0]   prog_length,
  input  logic                prog_done
);

  localparam int unsigned LEN_W = BUF_LOG2 + 1;
  localparam int unsigned BLK_W = ADDR_W - BLK_LOG2;
  localparam logic [LEN_W-1:0] BUF_WORDS = LEN_W'(1 << BUF_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ERASE,
    S_ERASE_WAIT,
    S_FIFO_WAIT,
    S_PROG,
    S_PROG_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [BLK_W-1:0]  erased_blk_q, erased_blk_d;
  logic              erased_vld_q, erased_vld_d;
  logic [LEN_W-1:0]  chunk_q, chunk_d;
  logic              abort_q, abort_d;

  logic              busy_w;
  logic              abort_pend;
  logic [BLK_W-1:0]  cur_blk;
  logic [LEN_W-1:0]  space;
  logic [LEN_W-1:0]  chunk_calc;

  always_comb begin
    busy_w     = (state_q != S_IDLE) && (state_q != S_DONE);
    abort_pend = abort_q | (save_abort & busy_w);
    cur_blk    = cur_addr_q[ADDR_W-1:BLK_LOG2];
    // Words left before the next buffer boundary; 1..2^BUF_LOG2.
    space      = BUF_WORDS - LEN_W'(cur_addr_q[BUF_LOG2-1:0]);
    chunk_calc = (rem_q < ADDR_W'(space)) ? rem_q[LEN_W-1:0] : space;
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    erased_blk_d = erased_blk_q;
    erased_vld_d = erased_vld_q;
    chunk_d      = chunk_q;
    abort_d      = abort_pend;

    case (state_q)
      S_IDLE: begin
        if (save_en) begin
          cur_addr_d   = save_addr;
          rem_d        = save_length;
          erased_vld_d = 1'b0;
          abort_d      = 1'b0;
          state_d      = S_CALC;
        end
      end
      S_CALC: begin
        if ((rem_q == '0) || abort_pend) begin
          state_d = S_DONE;
        end else begin
          chunk_d = chunk_calc;
          if (erased_vld_q && (erased_blk_q == cur_blk)) state_d = S_FIFO_WAIT;
          else                                           state_d = S_ERASE;
        end
      end
      S_ERASE: state_d = S_ERASE_WAIT;
      S_ERASE_WAIT: begin
        if (erase_done) begin
          erased_blk_d = cur_blk;
          erased_vld_d = 1'b1;
          state_d      = abort_pend ? S_DONE : S_FIFO_WAIT;
        end
      end
      S_FIFO_WAIT: begin
        if (abort_pend)                        state_d = S_DONE;
        else if (fifo_count >= {1'b0, chunk_q}) state_d = S_PROG;
      end
      S_PROG: state_d = S_PROG_WAIT;
      S_PROG_WAIT: begin
        if (prog_done) begin
          cur_addr_d = cur_addr_q + ADDR_W'(chunk_q);
          rem_d      = rem_q - ADDR_W'(chunk_q);
          state_d    = S_CALC;
        end
      end
      S_DONE: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      rem_q        <= '0;
      erased_blk_q <= '0;
      erased_vld_q <= 1'b0;
      chunk_q      <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      rem_q        <= rem_d;
      erased_blk_q <= erased_blk_d;
      erased_vld_q <= erased_vld_d;
      chunk_q      <= chunk_d;
      abort_q      <= abort_d;
    end
  end

  // Addresses and length come straight from registers that only move on a
  // completion pulse, so they stay stable for the whole handshake.
  always_comb begin
    busy         = busy_w;
    save_done    = (state_q == S_DONE);
    save_aborted = (state_q == S_DONE) & abort_q;
    erase_en     = (state_q == S_ERASE);
    erase_addr   = {cur_blk, {BLK_LOG2{1'b0}}};
    prog_en      = (state_q == S_PROG);
    prog_addr    = cur_addr_q;
    prog_length  = chunk_q;
  end

endmodule

// File: tb/tb_flash_save_sched.sv
// Randomized bench for flash_save_sched: a transaction-level model predicts every
// erase/program pulse, its timing, busy and save_done, checked each cycle.
module tb_flash_save_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        save_en;
  logic [24:0] save_addr;
  logic [24:0] save_length;
  logic        save_abort;
  logic [10:0] fifo_count;
  logic        busy, save_done, save_aborted;
  logic        erase_en, prog_en;
  logic [24:0] erase_addr, prog_addr;
  logic [9:0]  prog_length;
  logic        erase_done, prog_done;

  flash_save_sched #(.BUF_LOG2(9), .BLK_LOG2(16), .ADDR_W(25)) dut (
    .clk(clk), .rst_n(rst_n),
    .save_en(save_en), .save_addr(save_addr), .save_length(save_length),
    .save_abort(save_abort), .fifo_count(fifo_count),
    .busy(busy), .save_done(save_done), .save_aborted(save_aborted),
    .erase_en(erase_en), .erase_addr(erase_addr), .erase_done(erase_done),
    .prog_en(prog_en), .prog_addr(prog_addr), .prog_length(prog_length),
    .prog_done(prog_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: operation list ----------------
  typedef struct {
    bit er;
    int addr;
    int len;
  } op_t;
  op_t ops[$];

  function automatic void build_ops(input int addr, input int len);
    int a, r, ch, blk, last;
    bit have;
    op_t o;
    ops.delete();
    a = addr; r = len; have = 0; last = 0;
    while (r > 0) begin
      ch = 512 - (a % 512);
      if (r < ch) ch = r;
      blk = a / 65536;
      if (!have || blk != last) begin
        o.er = 1; o.addr = blk * 65536; o.len = 0;
        ops.push_back(o);
        have = 1; last = blk;
      end
      o.er = 0; o.addr = a; o.len = ch;
      ops.push_back(o);
      a = (a + ch) % (1 << 25);
      r = r - ch;
    end
  endfunction

  // ---------------- reference model: timing ----------------
  bit m_active, m_aborted;
  int exp_en_cyc, exp_en_addr, exp_en_len;
  bit exp_en_er;
  int fifo_from, exp_done_cyc, outstanding, out_addr, out_len, out_since, op_idx;

  function automatic void m_reset();
    m_active = 0; m_aborted = 0; exp_en_cyc = -1; fifo_from = -1;
    exp_done_cyc = -1; outstanding = 0; op_idx = 0; out_since = 0;
  endfunction

  function automatic void sched_en(input int c);
    exp_en_cyc  = c;
    exp_en_er   = ops[op_idx].er;
    exp_en_addr = ops[op_idx].addr;
    exp_en_len  = ops[op_idx].len;
  endfunction

  initial m_reset();

  always @(negedge clk) begin
    bit busy_e, er_e, pr_e, done_e, ab;
    if (!rst_n) begin
      chk(!(busy | save_done | save_aborted | erase_en | prog_en) &&
          erase_addr == '0 && prog_addr == '0 && prog_length == '0,
          "reset_outputs", int'({busy, save_done, save_aborted, erase_en, prog_en}), 0);
      m_reset();
    end else begin
      busy_e = m_active && cyc != exp_done_cyc;
      er_e   = (exp_en_cyc == cyc) && exp_en_er;
      pr_e   = (exp_en_cyc == cyc) && !exp_en_er;
      done_e = m_active && cyc == exp_done_cyc;
      chk(busy == busy_e, "busy", int'(busy), int'(busy_e));
      chk(erase_en == er_e, "erase_en", int'(erase_en), int'(er_e));
      if (er_e && erase_en) chk(int'(erase_addr) == exp_en_addr, "erase_addr", int'(erase_addr), exp_en_addr);
      chk(prog_en == pr_e, "prog_en", int'(prog_en), int'(pr_e));
      if (pr_e && prog_en) begin
        chk(int'(prog_addr) == exp_en_addr, "prog_addr", int'(prog_addr), exp_en_addr);
        chk(int'(prog_length) == exp_en_len, "prog_length", int'(prog_length), exp_en_len);
      end
      if (outstanding == 1) chk(int'(erase_addr) == out_addr, "erase_addr_hold", int'(erase_addr), out_addr);
      if (outstanding == 2) begin
        chk(int'(prog_addr) == out_addr, "prog_addr_hold", int'(prog_addr), out_addr);
        chk(int'(prog_length) == out_len, "prog_length_hold", int'(prog_length), out_len);
      end
      chk(save_done == done_e, "save_done", int'(save_done), int'(done_e));
      chk(save_aborted == (done_e && m_aborted), "save_aborted", int'(save_aborted), int'(done_e && m_aborted));

      ab = m_aborted || (save_abort && busy_e);
      if (done_e) begin
        m_reset();
      end else if (!m_active) begin
        if (save_en) begin
          build_ops(int'(save_addr), int'(save_length));
          op_idx = 0; m_active = 1; m_aborted = 0;
          if (ops.size() == 0) exp_done_cyc = cyc + 2;
          else sched_en(cyc + 2);
        end
      end else begin
        if (exp_en_cyc == cyc) begin
          outstanding = exp_en_er ? 1 : 2;
          out_addr = exp_en_addr; out_len = exp_en_len; out_since = cyc;
          op_idx++; exp_en_cyc = -1;
        end
        if (outstanding == 1 && erase_done && cyc > out_since) begin
          outstanding = 0;
          if (ab) exp_done_cyc = cyc + 1;
          else fifo_from = cyc + 1;
        end else if (outstanding == 2 && prog_done && cyc > out_since) begin
          outstanding = 0;
          if (ab || op_idx == ops.size()) exp_done_cyc = cyc + 2;
          else if (ops[op_idx].er) sched_en(cyc + 2);
          else fifo_from = cyc + 2;
        end
        if (fifo_from >= 0 && cyc >= fifo_from && !ab && int'(fifo_count) >= ops[op_idx].len) begin
          sched_en(cyc + 1);
          fifo_from = -1;
        end
        // A new abort stops any operation not yet launched; with nothing in flight it ends next cycle.
        if (save_abort && busy_e && !m_aborted) begin
          m_aborted = 1;
          exp_en_cyc = -1;
          fifo_from = -1;
          if (outstanding == 0 && exp_done_cyc < 0) exp_done_cyc = cyc + 1;
        end
      end
    end
  end

  // ---------------- controller stand-in ----------------
  initial begin
    int d;
    bit k;
    erase_done = 1'b0;
    prog_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && (erase_en || prog_en)) begin
        k = erase_en;
        d = int'($urandom_range(1, 6));
        repeat (d) @(posedge clk);
        #1;
        if (k) erase_done = 1'b1;
        else   prog_done  = 1'b1;
        @(posedge clk);
        #1;
        erase_done = 1'b0;
        prog_done  = 1'b0;
      end
    end
  end

  // ---------------- observation counters for directed checks ----------------
  int n_er, n_pr, done_cnt, done_cyc, prog_cyc;
  bit done_ab;

  always @(negedge clk) begin
    if (rst_n) begin
      if (erase_en) n_er++;
      if (prog_en) begin n_pr++; prog_cyc = cyc; end
      if (save_done) begin done_cnt++; done_cyc = cyc; done_ab = save_aborted; end
    end
  end

  task automatic clr_mon();
    n_er = 0; n_pr = 0; prog_cyc = -1; done_ab = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_save(input int a, input int l);
    save_addr   = 25'(a);
    save_length = 25'(l);
    save_en     = 1'b1;
    tick();
    save_en     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input string name);
    int n, d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      if (rnd) begin
        fifo_count = 11'($urandom_range(0, 1023));
        save_abort = ($urandom_range(0, 199) == 0);
        if (busy && $urandom_range(0, 49) == 0) begin
          save_en     = 1'b1;
          save_addr   = 25'($urandom);
          save_length = 25'($urandom_range(0, 999));
        end else begin
          save_en = 1'b0;
        end
      end
      tick();
      n++;
    end
    save_en = 1'b0;
    save_abort = 1'b0;
    chk(done_cnt != d0, {name, "_done_timeout"}, done_cnt - d0, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "time limit");
  end

  initial begin
    int c0, f, k, a, l, blk;
    rst_n = 1'b1;
    save_en = 1'b0; save_addr = '0; save_length = '0;
    save_abort = 1'b0; fifo_count = '0;
    done_cnt = 0; done_cyc = -1;
    clr_mon();
    #1 rst_n = 1'b0;

    // Pin the model against hand-derived operation lists.
    build_ops(0, 512);
    chk(ops.size() == 2, "model_aligned_n", ops.size(), 2);
    chk(ops[1].er == 0 && ops[1].addr == 0 && ops[1].len == 512, "model_aligned_prog", ops[1].len, 512);
    build_ops('h1F0, 40);
    chk(ops.size() == 3, "model_unaligned_n", ops.size(), 3);
    chk(ops[1].addr == 'h1F0 && ops[1].len == 16, "model_unaligned_p0", ops[1].len, 16);
    chk(ops[2].addr == 'h200 && ops[2].len == 24, "model_unaligned_p1", ops[2].len, 24);
    build_ops('hFF00, 512);
    chk(ops.size() == 4, "model_cross_n", ops.size(), 4);
    chk(ops[2].er == 1 && ops[2].addr == 'h10000, "model_cross_erase2", ops[2].addr, 'h10000);
    chk(ops[3].addr == 'h10000 && ops[3].len == 256, "model_cross_p1", ops[3].len, 256);
    build_ops('h1FFFF00, 512);
    chk(ops.size() == 4 && ops[2].addr == 0, "model_wrap_erase2", ops[2].addr, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();

    // Aligned single buffer
    fifo_count = 11'd512; clr_mon();
    start_save(0, 512);
    wait_done(200, 0, "aligned");
    chk(n_er == 1 && n_pr == 1, "aligned_ops", n_er * 16 + n_pr, 17);
    chk(done_ab == 0, "aligned_not_aborted", int'(done_ab), 0);

    // Unaligned across buffers
    fifo_count = 11'd1023; clr_mon();
    start_save('h1F0, 40);
    wait_done(200, 0, "unaligned");
    chk(n_er == 1 && n_pr == 2, "unaligned_ops", n_er * 16 + n_pr, 18);

    // Block crossing
    clr_mon();
    start_save('hFF00, 512);
    wait_done(200, 0, "cross");
    chk(n_er == 2 && n_pr == 2, "cross_ops", n_er * 16 + n_pr, 34);

    // FIFO starvation
    fifo_count = 11'd99; clr_mon();
    start_save('h300, 100);
    repeat (50) tick();
    chk(n_pr == 0, "starve_no_prog", n_pr, 0);
    fifo_count = 11'd100;
    f = cyc; k = 0;
    while (n_pr == 0 && k < 20) begin tick(); k++; end
    chk(prog_cyc == f + 1, "starve_prog_cycle", prog_cyc, f + 1);
    wait_done(200, 0, "starve");

    // Abort during the first program burst
    fifo_count = 11'd1023; clr_mon();
    start_save(0, 2048);
    k = 0;
    while (n_pr == 0 && k < 50) begin tick(); k++; end
    save_abort = 1'b1;
    tick();
    save_abort = 1'b0;
    wait_done(100, 0, "abort");
    chk(n_pr == 1, "abort_single_prog", n_pr, 1);
    chk(done_ab == 1, "abort_flag", int'(done_ab), 1);

    // Zero length
    clr_mon();
    c0 = cyc;
    start_save('h1234, 0);
    wait_done(20, 0, "zero");
    chk(done_cyc == c0 + 2, "zero_done_cycle", done_cyc, c0 + 2);
    chk(n_er == 0 && n_pr == 0, "zero_no_ops", n_er + n_pr, 0);

    // Request while busy is ignored
    clr_mon();
    start_save('h20000, 300);
    repeat (3) tick();
    save_addr = 25'h40000; save_length = 25'd700; save_en = 1'b1;
    tick();
    save_en = 1'b0;
    wait_done(200, 0, "ignored");
    repeat (10) tick();
    chk(n_er == 1 && n_pr == 1, "ignored_ops", n_er * 16 + n_pr, 17);

    // Abort while idle has no effect
    save_abort = 1'b1;
    repeat (3) tick();
    save_abort = 1'b0;
    clr_mon();
    start_save('h50, 60);
    wait_done(200, 0, "idle_abort");
    chk(done_ab == 0 && n_pr == 1, "idle_abort_ops", int'(done_ab) * 16 + n_pr, 1);

    // Reset mid-operation
    start_save(0, 3000);
    repeat (15) tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // Randomized saves
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = int'($urandom_range(0, 33554431));
        1: begin
          blk = int'($urandom_range(1, 511));
          a = blk * 65536 - int'($urandom_range(0, 600));
        end
        2: a = 33554431 - int'($urandom_range(0, 700));
        default: a = int'($urandom_range(0, 65535)) * 512;
      endcase
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1800));
      fifo_count = 11'($urandom_range(0, 1023));
      clr_mon();
      start_save(a, l);
      wait_done(4000, 1, "rand");
      tick(); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_save_sched.md
Name: flash_save_sched

Overview:
- Sequencer that sits directly upstream of the flash controller top (erase/prog/read wrapper).
- Turns one "save N words at address A" request into the required series of block erases and buffer-sized program bursts, issued on the controller's erase_en/prog_en pulse handshakes.
- Holds off each program burst until the source FIFO (camera frame data) holds enough words, so the controller's fifo_rd_en never underruns.

Parameters:
- BUF_LOG2, 9, log2 of program buffer size in words (512).
- BLK_LOG2, 16, log2 of erase block size in words (64K words).
- ADDR_W, 25, word-address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- save_en  in  1  one-cycle request pulse; sampled only in IDLE.
- save_addr  in  25  start word address, captured on save_en.
- save_length  in  25  number of words to store, captured on save_en.
- save_abort  in  1  level; stop after the current flash operation completes.
- fifo_count  in  11  words currently available in the source FIFO.
- busy  out  1  high from the cycle after accepted save_en until save_done.
- save_done  out  1  one-cycle pulse at end of a save (normal or aborted).
- save_aborted  out  1  valid with save_done; 1 if the save ended by abort.
- erase_en  out  1  one-cycle pulse to the controller.
- erase_addr  out  25  block address; held stable from erase_en until erase_done.
- erase_done  in  1  one-cycle completion pulse from the controller.
- prog_en  out  1  one-cycle pulse to the controller.
- prog_addr  out  25  burst start address; held stable until prog_done.
- prog_length  out  10  burst word count, 1..512; held stable until prog_done.
- prog_done  in  1  one-cycle completion pulse from the controller.

Behaviour:
- Reset: all outputs 0; internal registers 0; state IDLE. Reset mid-operation abandons the operation immediately; the controller is reset by the same rst_n.
- Registers:
  - cur_addr (25b); rem (25b, words left).
  - erased_blk: block index cur_addr[24:BLK_LOG2], plus a valid flag.
- States and transitions:
  - IDLE: on save_en, capture addr/length, clear the erased flag, go to CALC. busy=1 from the next cycle.
  - CALC:
    - If rem==0 or abort is pending, go to DONE.
    - Otherwise compute chunk = min(rem, 2^BUF_LOG2 - cur_addr[BUF_LOG2-1:0]). chunk is always 1..512, so a burst never crosses a buffer boundary (and therefore never crosses a block boundary).
    - If the block of cur_addr is not yet erased, go to ERASE; else go to FIFO_WAIT.
  - ERASE: erase_en=1 for one cycle; erase_addr = {cur_addr[24:BLK_LOG2], zeros}. Go to ERASE_WAIT.
  - ERASE_WAIT: on erase_done, record erased_blk and set valid. Go to FIFO_WAIT, or to DONE if abort is pending.
  - FIFO_WAIT: wait until fifo_count >= chunk (unsigned compare, 11 bits). Go to PROG. If abort is pending, go to DONE instead.
  - PROG: prog_en=1 for one cycle; prog_addr=cur_addr; prog_length=chunk[9:0]. Go to PROG_WAIT.
  - PROG_WAIT: on prog_done, set cur_addr += chunk (wrap-around modulo 2^25 allowed) and rem -= chunk. Go to CALC.
  - DONE: save_done=1 and save_aborted=abort_pending for one cycle; busy=0 in the same cycle. Return to IDLE.
- Erase policy:
  - The first block touched is always erased, even when save_addr is not block-aligned.
  - Each subsequent block is erased exactly once, when cur_addr first enters it.
- Abort:
  - save_abort asserted any cycle while busy sets abort_pending (sticky until DONE).
  - An in-flight erase or program is never cut short; the block leaves at the next CALC/ERASE_WAIT/FIFO_WAIT decision point.
- Edge cases:
  - save_length=0: sequence is IDLE -> CALC -> DONE; save_done 2 cycles after save_en, with no erase or program.
  - save_en while busy is ignored.
  - erase_done/prog_done outside their WAIT states are ignored.
  - save_abort while IDLE has no effect.
- Latency: erase_en is pulsed 2 cycles after save_en. prog_en is pulsed 1 cycle after FIFO_WAIT is satisfied.

Test Plan:
- Aligned, one buffer: save_addr=0x000000, save_length=512, fifo_count=512 -> one erase at 0x000000, then one prog at 0x000000 with length 512, then save_done with save_aborted=0.
- Unaligned across buffers: addr=0x0001F0, len=40 -> erase 0x000000; prog(0x0001F0, 16); prog(0x000200, 24); no second erase.
- Block crossing: addr=0x00FF00, len=512 -> erase 0x000000; prog(0x00FF00, 256); erase 0x010000; prog(0x010000, 256).
- FIFO starvation: len=100, fifo_count held at 99 for 50 cycles, then 100 -> prog_en stays low until the cycle after fifo_count=100.
- Abort during PROG_WAIT: len=2048, abort asserted mid-first burst -> the first prog completes, no further prog_en, save_done with save_aborted=1.
- Zero length and ignored request: len=0 -> save_done 2 cycles after save_en with no erase/prog. A second save_en while busy produces no extra operations.
